// File: rtl/start_edge_detect_pkg.sv
// Shared constants for the START edge detector: phase codes and default
// synchroniser depth.
package start_edge_detect_pkg;

  localparam logic [1:0] PH_NONE  = 2'b00;
  localparam logic [1:0] PH_LATE  = 2'b01;
  localparam logic [1:0] PH_EARLY = 2'b10;

  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/start_edge_detect_sync_chain.sv
// Posedge shift-register synchroniser with asynchronous active-low clear.
// DEPTH must be at least 2.
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/start_edge_detect.sv
// Half-period resolution rising-edge detector for the asynchronous START
// input; reports a phase code and a one-cycle strobe on posedge clk.
module start_edge_detect
  import start_edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter bit ONE_SHOT    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [1:0] out,
  output logic       edge_flag
);

  logic       r_n_cap;
  logic       w_p_sync;
  logic       w_n_sync;
  logic       r_p_win;
  logic       r_p_prev;
  logic       r_n_win;
  logic       r_armed;
  logic [1:0] r_out;
  logic       r_edge_flag;
  logic       w_edge;
  logic [1:0] w_phase;

  // The N path is captured on the falling edge and then re-timed on the
  // rising edge, so both chain outputs describe the same posedge window.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_n_cap <= 1'b0;
    end else begin
      r_n_cap <= in;
    end
  end

  sync_chain #(.DEPTH(SYNC_STAGES)) u_sync_p (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (in),
    .o_q     (w_p_sync)
  );

  sync_chain #(.DEPTH(SYNC_STAGES)) u_sync_n (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (r_n_cap),
    .o_q     (w_n_sync)
  );

  // Window stage: P(k-1), N(k), P(k) held side by side.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p_win  <= 1'b0;
      r_p_prev <= 1'b0;
      r_n_win  <= 1'b0;
    end else begin
      r_p_win  <= w_p_sync;
      r_p_prev <= r_p_win;
      r_n_win  <= w_n_sync;
    end
  end

  // A short pulse seen only by N never makes P rise, so it is ignored here.
  assign w_edge  = r_p_win & ~r_p_prev & r_armed;
  assign w_phase = r_n_win ? PH_EARLY : PH_LATE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out       <= PH_NONE;
      r_edge_flag <= 1'b0;
      r_armed     <= 1'b1;
    end else begin
      r_edge_flag <= w_edge;
      if (w_edge) begin
        r_out <= w_phase;
        if (ONE_SHOT) begin
          r_armed <= 1'b0;
        end
      end
    end
  end

  assign out       = r_out;
  assign edge_flag = r_edge_flag;

endmodule

// File: tb/tb_start_edge_detect.sv
// Directed bench for start_edge_detect: one-shot and free-running
// instances share the same START and reset stimulus.
`timescale 1ns/100ps
module tb_start_edge_detect;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       in    = 1'b0;
  logic [1:0] out_os;
  logic [1:0] out_mu;
  logic       flag_os;
  logic       flag_mu;

  int n_cmp = 0;
  int n_bad = 0;

  always #2 clk = ~clk;

  start_edge_detect #(.SYNC_STAGES(2), .ONE_SHOT(1'b1)) dut_os (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .out       (out_os),
    .edge_flag (flag_os)
  );

  start_edge_detect #(.SYNC_STAGES(2), .ONE_SHOT(1'b0)) dut_mu (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .out       (out_mu),
    .edge_flag (flag_mu)
  );

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    in    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (out_os !== 2'b00) begin n_bad++; $display("FAIL reset_out_os got=%b exp=00", out_os); end
    n_cmp++; if (out_mu !== 2'b00) begin n_bad++; $display("FAIL reset_out_mu got=%b exp=00", out_mu); end
    n_cmp++; if (flag_os !== 1'b0) begin n_bad++; $display("FAIL reset_flag_os got=%b exp=0", flag_os); end
    n_cmp++; if (flag_mu !== 1'b0) begin n_bad++; $display("FAIL reset_flag_mu got=%b exp=0", flag_mu); end
    do_reset();
    n_cmp++; if (out_os !== 2'b00) begin n_bad++; $display("FAIL idle_out_os got=%b exp=00", out_os); end
    n_cmp++; if (flag_mu !== 1'b0) begin n_bad++; $display("FAIL idle_flag_mu got=%b exp=0", flag_mu); end
  endtask

  // Rise 1 ns after a posedge: before the negedge, so early half.
  task automatic test_early();
    logic exp_f;
    do_reset();
    @(posedge clk); #1 in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp_f = (i == 3);
      n_cmp++; if (flag_os !== exp_f) begin n_bad++; $display("FAIL early_flag_os cyc=%0d got=%b exp=%b", i, flag_os, exp_f); end
      n_cmp++; if (flag_mu !== exp_f) begin n_bad++; $display("FAIL early_flag_mu cyc=%0d got=%b exp=%b", i, flag_mu, exp_f); end
      if (i == 3) begin
        n_cmp++; if (out_os !== 2'b10) begin n_bad++; $display("FAIL early_out_os got=%b exp=10", out_os); end
        n_cmp++; if (out_mu !== 2'b10) begin n_bad++; $display("FAIL early_out_mu got=%b exp=10", out_mu); end
      end
    end
  endtask

  // Rise 3 ns after a posedge: after the negedge, so late half.
  task automatic test_late();
    logic exp_f;
    do_reset();
    @(posedge clk); #3 in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp_f = (i == 3);
      n_cmp++; if (flag_os !== exp_f) begin n_bad++; $display("FAIL late_flag_os cyc=%0d got=%b exp=%b", i, flag_os, exp_f); end
      if (i == 3) begin
        n_cmp++; if (out_os !== 2'b01) begin n_bad++; $display("FAIL late_out_os got=%b exp=01", out_os); end
        n_cmp++; if (out_mu !== 2'b01) begin n_bad++; $display("FAIL late_out_mu got=%b exp=01", out_mu); end
      end
    end
  endtask

  task automatic test_one_shot();
    int c_os = 0;
    int c_mu = 0;
    do_reset();
    @(posedge clk); #1 in = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (flag_os) c_os++; if (flag_mu) c_mu++; end
    in = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (flag_os) c_os++; if (flag_mu) c_mu++; end
    @(posedge clk); #3 in = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (flag_os) c_os++; if (flag_mu) c_mu++; end
    n_cmp++; if (c_os !== 1) begin n_bad++; $display("FAIL oneshot_count_os got=%0d exp=1", c_os); end
    n_cmp++; if (c_mu !== 2) begin n_bad++; $display("FAIL multi_count_mu got=%0d exp=2", c_mu); end
    n_cmp++; if (out_os !== 2'b10) begin n_bad++; $display("FAIL oneshot_out_os got=%b exp=10", out_os); end
    n_cmp++; if (out_mu !== 2'b01) begin n_bad++; $display("FAIL multi_out_mu got=%b exp=01", out_mu); end
  endtask

  task automatic test_long_hold();
    int c_os = 0;
    int c_mu = 0;
    do_reset();
    @(posedge clk); #1 in = 1'b1;
    repeat (425) begin @(posedge clk); #1; if (flag_os) c_os++; if (flag_mu) c_mu++; end
    n_cmp++; if (c_os !== 1) begin n_bad++; $display("FAIL hold_rise_count_os got=%0d exp=1", c_os); end
    n_cmp++; if (c_mu !== 1) begin n_bad++; $display("FAIL hold_rise_count_mu got=%0d exp=1", c_mu); end
    c_os = 0;
    c_mu = 0;
    in = 1'b0;
    repeat (750) begin @(posedge clk); #1; if (flag_os) c_os++; if (flag_mu) c_mu++; end
    n_cmp++; if (c_os !== 0) begin n_bad++; $display("FAIL hold_fall_count_os got=%0d exp=0", c_os); end
    n_cmp++; if (c_mu !== 0) begin n_bad++; $display("FAIL hold_fall_count_mu got=%0d exp=0", c_mu); end
    n_cmp++; if (out_os !== 2'b10) begin n_bad++; $display("FAIL hold_out_os got=%b exp=10", out_os); end
    n_cmp++; if (out_mu !== 2'b10) begin n_bad++; $display("FAIL hold_out_mu got=%b exp=10", out_mu); end
  endtask

  // 1 ns pulse around a negedge only: seen by N, never by P.
  task automatic test_glitch();
    int c_os = 0;
    int c_mu = 0;
    do_reset();
    @(posedge clk); #1.5 in = 1'b1;
    #1 in = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (flag_os) c_os++; if (flag_mu) c_mu++; end
    n_cmp++; if (c_os !== 0) begin n_bad++; $display("FAIL glitch_count_os got=%0d exp=0", c_os); end
    n_cmp++; if (c_mu !== 0) begin n_bad++; $display("FAIL glitch_count_mu got=%0d exp=0", c_mu); end
    n_cmp++; if (out_os !== 2'b00) begin n_bad++; $display("FAIL glitch_out_os got=%b exp=00", out_os); end
    n_cmp++; if (out_mu !== 2'b00) begin n_bad++; $display("FAIL glitch_out_mu got=%b exp=00", out_mu); end
  endtask

  task automatic test_reset_mid();
    int   c_mu = 0;
    logic exp_f;
    do_reset();
    @(posedge clk); #1 in = 1'b1;
    repeat (6) @(posedge clk);
    #1 in = 1'b0;
    repeat (4) @(posedge clk);
    n_cmp++; if (out_mu !== 2'b10) begin n_bad++; $display("FAIL mid_pre_out_mu got=%b exp=10", out_mu); end
    @(posedge clk); #3 in = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    #0.5;
    n_cmp++; if (out_mu !== 2'b00) begin n_bad++; $display("FAIL mid_rst_out_mu got=%b exp=00", out_mu); end
    n_cmp++; if (out_os !== 2'b00) begin n_bad++; $display("FAIL mid_rst_out_os got=%b exp=00", out_os); end
    n_cmp++; if (flag_mu !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flag_mu got=%b exp=0", flag_mu); end
    repeat (3) begin @(posedge clk); #1; if (flag_mu) c_mu++; end
    n_cmp++; if (c_mu !== 0) begin n_bad++; $display("FAIL mid_held_count_mu got=%0d exp=0", c_mu); end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp_f = (i == 3);
      n_cmp++; if (flag_os !== exp_f) begin n_bad++; $display("FAIL rel_flag_os cyc=%0d got=%b exp=%b", i, flag_os, exp_f); end
      n_cmp++; if (flag_mu !== exp_f) begin n_bad++; $display("FAIL rel_flag_mu cyc=%0d got=%b exp=%b", i, flag_mu, exp_f); end
      if (i == 3) begin
        n_cmp++; if (out_os !== 2'b10) begin n_bad++; $display("FAIL rel_out_os got=%b exp=10", out_os); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_early();
    test_late();
    test_one_shot();
    test_long_hold();
    test_glitch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
